// File: rtl/patch_eq_pkg.sv
// Shared types and constants for the ECO patch equivalence harness.
package patch_eq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Bit positions of the patch input nets inside stim for the 4-input patch.
  localparam int STIM_N29 = 0;
  localparam int STIM_N31 = 1;
  localparam int STIM_N33 = 2;
  localparam int STIM_N36 = 3;

  localparam int SETTLE_W = 8;

endpackage

// File: rtl/patch_settle_timer.sv
// Loadable down-counter that reports when it has reached zero.
module patch_settle_timer
  import patch_eq_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; the counter parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/patch_eq_checker.sv
// Exhaustive stimulus/response checker comparing a patch netlist against its golden output.
module patch_eq_checker
  import patch_eq_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            patch_out,
  input  logic            golden_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);

  state_t state;
  logic   timer_load;
  logic   timer_dec;
  logic   timer_zero;
  logic   mismatch;
  logic   last_vec;

  assign mismatch = patch_out ^ golden_out;
  assign last_vec = &stim;

  always_comb begin
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE:    timer_load = start;
      HOLD:    timer_dec  = !timer_zero;
      CHECK:   timer_load = !last_vec;
      default: ;
    endcase
  end

  patch_settle_timer #(
    .W(SETTLE_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_VAL),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  // pass is resolved on entry to FINISH so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state            <= HOLD;
            stim             <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        HOLD: begin
          if (timer_zero) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= stim;
            end
          end
          if (last_vec) begin
            state <= FINISH;
            done  <= 1'b1;
            pass  <= (mismatch_cnt == '0) && !mismatch;
          end else begin
            stim  <= stim + 1'b1;
            state <= HOLD;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_eq_checker.sv
// Table-driven and randomized bench for patch_eq_checker at SETTLE = 1, 0 and 3.
module tb_patch_eq_checker;
  import patch_eq_pkg::*;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a [NDUT];
  logic       patch_a [NDUT];
  logic       golden_a[NDUT];
  logic [3:0] stim_a  [NDUT];
  logic       busy_a  [NDUT];
  logic       done_a  [NDUT];
  logic       pass_a  [NDUT];
  logic [4:0] cnt_a   [NDUT];
  logic       ffv_a   [NDUT];
  logic [3:0] ffvec_a [NDUT];

  logic [15:0] fmask;
  logic        stuck0;
  int          checks = 0;
  int          errors = 0;
  int          settle_of[NDUT] = '{1, 0, 3};

  always #5 clk = ~clk;

  function automatic logic gold(input logic [3:0] v);
    return v[STIM_N36] | (v[STIM_N29] & ~v[STIM_N31] & ~v[STIM_N33]);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_resp
    assign golden_a[g] = gold(stim_a[g]);
    assign patch_a[g]  = stuck0 ? 1'b0 : (gold(stim_a[g]) ^ fmask[stim_a[g]]);
  end

  patch_eq_checker #(.N_IN(4), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .patch_out(patch_a[0]),
    .golden_out(golden_a[0]), .stim(stim_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .pass(pass_a[0]), .mismatch_cnt(cnt_a[0]), .first_fail_valid(ffv_a[0]),
    .first_fail_vec(ffvec_a[0]));

  patch_eq_checker #(.N_IN(4), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .patch_out(patch_a[1]),
    .golden_out(golden_a[1]), .stim(stim_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .pass(pass_a[1]), .mismatch_cnt(cnt_a[1]), .first_fail_valid(ffv_a[1]),
    .first_fail_vec(ffvec_a[1]));

  patch_eq_checker #(.N_IN(4), .SETTLE(3)) dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .patch_out(patch_a[2]),
    .golden_out(golden_a[2]), .stim(stim_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .pass(pass_a[2]), .mismatch_cnt(cnt_a[2]), .first_fail_valid(ffv_a[2]),
    .first_fail_vec(ffvec_a[2]));

  typedef struct {
    logic [15:0] mask;
    logic        stuck0;
    bit          noisy;
    int          exp_cnt;
    logic        exp_ffv;
    logic [3:0]  exp_ffvec;
    logic        exp_pass;
  } vec_t;

  vec_t tbl[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk every vector in order and compare patch against golden directly.
  task automatic refModel(input logic [15:0] mask, input logic s0, output int cnt,
                          output logic ffv, output logic [3:0] ffvec, output logic ok);
    cnt = 0; ffv = 1'b0; ffvec = 4'h0;
    for (int v = 0; v < 16; v++) begin
      logic g, p;
      g = gold(4'(v));
      p = s0 ? 1'b0 : (g ^ mask[v]);
      if (p != g) begin
        if (!ffv) begin
          ffv = 1'b1;
          ffvec = 4'(v);
        end
        cnt++;
      end
    end
    ok = (cnt == 0);
  endtask

  task automatic checkReset(input int sel);
    checkOutput("rst_stim", 32'(stim_a[sel]), 0);
    checkOutput("rst_busy", 32'(busy_a[sel]), 0);
    checkOutput("rst_done", 32'(done_a[sel]), 0);
    checkOutput("rst_pass", 32'(pass_a[sel]), 0);
    checkOutput("rst_cnt", 32'(cnt_a[sel]), 0);
    checkOutput("rst_ffv", 32'(ffv_a[sel]), 0);
    checkOutput("rst_ffvec", 32'(ffvec_a[sel]), 0);
  endtask

  // Start a run on one DUT; k counts cycles after the start edge, done expected at k = 16*(S+2).
  task automatic applyStimulus(input int sel, input bit noisy, output int done_k, output int bad_stim);
    int settle;
    settle = settle_of[sel];
    done_k = -1;
    bad_stim = 0;
    start_a[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a[sel] = 1'b0;
    for (int k = 0; k <= 400 && done_k < 0; k++) begin
      if (k == 0) begin
        checkOutput("start_busy", 32'(busy_a[sel]), 1);
        checkOutput("start_cnt_clr", 32'(cnt_a[sel]), 0);
        checkOutput("start_ffv_clr", 32'(ffv_a[sel]), 0);
        checkOutput("start_pass_clr", 32'(pass_a[sel]), 0);
      end
      if (done_a[sel]) begin
        done_k = k;
        start_a[sel] = noisy;
      end else begin
        if (int'(stim_a[sel]) != k / (settle + 2)) bad_stim++;
        if (noisy) start_a[sel] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);
    end
    start_a[sel] = 1'b0;
    checkOutput("done_pulse", 32'(done_a[sel]), 0);
    checkOutput("busy_after", 32'(busy_a[sel]), 0);
    checkOutput("stim_last", 32'(stim_a[sel]), 15);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done_k, bad, ecnt;
    logic effv, eok;
    logic [3:0] effvec;

    tbl[0] = '{16'h0000, 1'b0, 1'b0, 0, 1'b0, 4'h0, 1'b1};
    tbl[1] = '{16'h0000, 1'b1, 1'b0, 9, 1'b1, 4'h1, 1'b0};
    tbl[2] = '{16'h0040, 1'b0, 1'b0, 1, 1'b1, 4'h6, 1'b0};
    for (int i = 3; i < 7; i++) begin
      tbl[i].mask   = (i == 4) ? 16'($urandom_range(1, 65535)) : 16'($urandom & $urandom);
      tbl[i].stuck0 = 1'b0;
      tbl[i].noisy  = (i == 4);
      refModel(tbl[i].mask, 1'b0, ecnt, effv, effvec, eok);
      tbl[i].exp_cnt = ecnt; tbl[i].exp_ffv = effv;
      tbl[i].exp_ffvec = effvec; tbl[i].exp_pass = eok;
    end

    for (int i = 0; i < NDUT; i++) start_a[i] = 1'b0;
    fmask = 16'h0000;
    stuck0 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset(0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      fmask = tbl[i].mask;
      stuck0 = tbl[i].stuck0;
      applyStimulus(0, tbl[i].noisy, done_k, bad);
      $display("[TB] vector %0d mask=%04h stuck0=%0b done_k=%0d", i, tbl[i].mask, tbl[i].stuck0, done_k);
      checkOutput("done_cycle", 32'(done_k), 48);
      checkOutput("stim_hold", 32'(bad), 0);
      checkOutput("pass", 32'(pass_a[0]), 32'(tbl[i].exp_pass));
      checkOutput("mismatch_cnt", 32'(cnt_a[0]), 32'(tbl[i].exp_cnt));
      checkOutput("first_fail_valid", 32'(ffv_a[0]), 32'(tbl[i].exp_ffv));
      checkOutput("first_fail_vec", 32'(ffvec_a[0]), 32'(tbl[i].exp_ffvec));
    end

    fmask = 16'h0000;
    stuck0 = 1'b0;
    applyStimulus(1, 1'b0, done_k, bad);
    checkOutput("s0_done_cycle", 32'(done_k), 32);
    checkOutput("s0_stim_hold", 32'(bad), 0);
    checkOutput("s0_pass", 32'(pass_a[1]), 1);
    applyStimulus(2, 1'b0, done_k, bad);
    checkOutput("s3_done_cycle", 32'(done_k), 80);
    checkOutput("s3_stim_hold", 32'(bad), 0);
    checkOutput("s3_pass", 32'(pass_a[2]), 1);

    // Reset mid-run with start held high; an early fault makes partial results visible first.
    fmask = 16'h0001;
    start_a[0] = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("midrun_busy", 32'(busy_a[0]), 1);
    checkOutput("midrun_cnt", 32'(cnt_a[0]), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkReset(0);
    rst_n = 1'b1;
    start_a[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_after_rst", 32'(busy_a[0]), 0);
    applyStimulus(0, 1'b0, done_k, bad);
    checkOutput("post_rst_done", 32'(done_k), 48);
    checkOutput("post_rst_cnt", 32'(cnt_a[0]), 1);
    checkOutput("post_rst_ffvec", 32'(ffvec_a[0]), 0);
    checkOutput("post_rst_pass", 32'(pass_a[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_eq_checker.md
Name: patch_eq_checker

Overview:
- Sequential stimulus/response harness that drives the input side of a combinational ECO patch netlist and checks its output against a golden reference output.
- Exhaustively enumerates all 2^N_IN input vectors, waits a fixed settle time per vector, compares, and counts mismatches.
- Reports pass/fail and the first failing vector.
- Sits beside a patch instance (e.g. 4-input patch on n29/n31/n33/n36) in the ECO validation top.

Parameters:
- N_IN, 4, number of patch inputs enumerated (1..16).
- SETTLE, 1, extra cycles each vector is held before sampling (0..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a run; honoured only in IDLE.
- patch_out  input  1  output of patch under test.
- golden_out  input  1  golden output for the current stim.
- stim  output  N_IN  vector driven to the patch. Bit map for the 4-input case: [0]=n29, [1]=n31, [2]=n33, [3]=n36.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  valid when done or after done: 1 iff mismatch_cnt==0.
- mismatch_cnt  output  N_IN+1  number of failing vectors in the last run.
- first_fail_valid  output  1  at least one mismatch seen in the last run.
- first_fail_vec  output  N_IN  stim value of the first mismatch.

Behaviour:
- Reset (rst_n=0 at a clk edge) is synchronous.
  - Outputs after reset: stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_valid=0, first_fail_vec=0.
  - The FSM goes to IDLE.
  - Reset wins over all other inputs, including mid-run; partial results are discarded.
- FSM states: IDLE, HOLD, CHECK, FINISH.
- IDLE:
  - start=1 -> HOLD.
  - On that edge: stim<=0, settle_cnt<=SETTLE, busy<=1.
  - Also clear mismatch_cnt, first_fail_valid, first_fail_vec and pass.
- HOLD:
  - settle_cnt==0 -> CHECK.
  - Otherwise decrement settle_cnt.
- CHECK: a single cycle in which patch_out and golden_out are sampled.
  - On mismatch: mismatch_cnt++.
  - On the first mismatch of the run, also first_fail_vec<=stim and first_fail_valid<=1.
  - If stim == all-ones -> FINISH.
  - Else stim<=stim+1, settle_cnt<=SETTLE -> HOLD.
- FINISH: a single cycle.
  - done=1, busy<=0, pass<=(final mismatch_cnt==0).
  - Next state is IDLE.
  - stim holds its last value (all-ones) until the next start.
- Timing:
  - Each vector is held exactly SETTLE+2 cycles (HOLD SETTLE+1 cycles, CHECK 1 cycle).
  - done is high in the cycle 2^N_IN*(SETTLE+2) cycles after the start edge.
- start is ignored while busy.
  - start asserted during FINISH is ignored.
  - start in IDLE the cycle after done begins a new run.
- mismatch_cnt never wraps: its width holds 2^N_IN, the maximum count.
- Results (pass, mismatch_cnt, first_fail_*) hold after done until the next accepted start or reset.
- stim increments unsigned and never wraps within a run.
- Inputs patch_out and golden_out are sampled only in CHECK.
  - X/changes outside CHECK have no effect.

Decomposition:
- Package patch_eq_pkg holds:
  - state enum {IDLE, HOLD, CHECK, FINISH};
  - stim bit index constants (STIM_N29=0, STIM_N31=1, STIM_N33=2, STIM_N36=3);
  - SETTLE counter width constant (8).
- Sub-module patch_settle_timer: loadable down-counter with a zero flag.
- FSM, stim counter and result registers stay in patch_eq_checker.

Test Plan:
1. Identical outputs: golden_out=patch_out = stim[3] | (stim[0]&~stim[1]&~stim[2]), N_IN=4, SETTLE=1, start pulse -> done at cycle 48, pass=1, mismatch_cnt=0, first_fail_valid=0.
2. Patch stuck-at-0 vs the golden function above -> mismatch_cnt=9, first_fail_vec=4'b0001, first_fail_valid=1, pass=0.
3. Single-vector fault: patch differs from golden only at stim=4'b0110 -> mismatch_cnt=1, first_fail_vec=4'b0110.
4. SETTLE=0 with the same stimulus as case 1 -> done at cycle 32. With SETTLE=3 -> done at cycle 80. stim is stable for every cycle of each hold.
5. rst_n=0 at cycle 10 of a run, with start held high through the reset -> all outputs at their reset values on the next edge. After rst_n returns high, start is accepted in IDLE and a full run completes.
6. start pulsed during HOLD, during CHECK and during FINISH -> no restart, counts unaffected. start the cycle after done -> new run with cleared results.
